// File: rtl/mux81_pkg.sv
// Shared constants for the 8:1 registered bit multiplexer.
// Select bit 0 carries the most significant lane weight.
package mux81_pkg;
  localparam int N_IN  = 8;
  localparam int SEL_W = 3;
endpackage

// File: rtl/mux81_if.sv
// Data, select and registered output bundle for mux81.
// Master drives lanes and select; slave returns the chosen bit.
interface mux81_if;
  import mux81_pkg::*;

  logic [N_IN-1:0]  i;
  logic [SEL_W-1:0] s;
  logic             y;

  modport master (
    output i,
    output s,
    input  y
  );

  modport slave (
    input  i,
    input  s,
    output y
  );
endinterface

// File: rtl/mux81_mux21.sv
// Two-input bit multiplexer used as the leaf cell of the mux81 tree.
// Purely combinational: y follows b when sel is high, else a.
module mux21 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/mux81.sv
// Registered 8:1 bit mux built from a three-level mux21 tree.
// s[2] picks within lane pairs, s[1] within quads, s[0] between halves.
module mux81
  import mux81_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  mux81_if.slave   bus
);
  logic [N_IN/2-1:0] l1;
  logic [N_IN/4-1:0] l2;
  logic              tree_y;
  logic              y_d;
  logic              y_q;

  for (genvar g = 0; g < N_IN/2; g++) begin : g_l1
    mux21 u_mux (
      .a   (bus.i[2*g]),
      .b   (bus.i[2*g+1]),
      .sel (bus.s[2]),
      .y   (l1[g])
    );
  end

  for (genvar g = 0; g < N_IN/4; g++) begin : g_l2
    mux21 u_mux (
      .a   (l1[2*g]),
      .b   (l1[2*g+1]),
      .sel (bus.s[1]),
      .y   (l2[g])
    );
  end

  mux21 u_l3 (
    .a   (l2[0]),
    .b   (l2[1]),
    .sel (bus.s[0]),
    .y   (tree_y)
  );

  always_comb begin
    y_d = tree_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y_d;
    end
  end

  assign bus.y = y_q;
endmodule

// File: tb/tb_mux81.sv
// Self-checking bench for mux81: scoreboard of expected y values
// pushed at stimulus time and popped one clock edge later.
module tb_mux81;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic exp;
  logic held;
  logic sb[$];

  mux81_if bus ();

  mux81 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  // Lane k maps to s[0]=k[2], s[1]=k[1], s[2]=k[0].
  function automatic logic [2:0] sel_of(input int k);
    logic [2:0] kv;
    logic [2:0] sv;
    kv = k[2:0];
    sv[0] = kv[2];
    sv[1] = kv[1];
    sv[2] = kv[0];
    return sv;
  endfunction

  function automatic logic model(input logic [7:0] iv,
                                 input logic [2:0] sv);
    int idx;
    idx = 4 * int'(sv[0]) + 2 * int'(sv[1]) + int'(sv[2]);
    return iv[idx];
  endfunction

  task automatic apply(input logic [7:0] iv, input logic [2:0] sv);
    @(negedge clk);
    bus.i = iv;
    bus.s = sv;
    sb.push_back(model(iv, sv));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.i = 8'hFF;
    bus.s = 3'b000;
    #1;
    n_chk++;
    if (bus.y !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_now: y=%b want 0", bus.y);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (bus.y !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: y=%b want 0", c, bus.y);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (bus.y !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: y=%b want 1", bus.y);
    end
  endtask

  task automatic test_walking_one;
    for (int k = 0; k < 8; k++) begin
      apply(8'(1 << k), sel_of(k));
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      n_chk++;
      if (bus.y !== exp || exp !== 1'b1) begin
        n_fail++;
        $display("FAIL walk1[%0d]: y=%b want %b", k, bus.y, exp);
      end
    end
  endtask

  task automatic test_walking_zero;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        apply(~8'(1 << k), sel_of(j));
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        n_chk++;
        if (bus.y !== exp || exp !== (j != k)) begin
          n_fail++;
          $display("FAIL walk0[%0d,%0d]: y=%b want %b",
                   k, j, bus.y, exp);
        end
      end
    end
  endtask

  task automatic test_all_zero;
    apply(8'hFF, 3'b000);
    @(posedge clk);
    #1;
    void'(sb.pop_front());
    for (int j = 0; j < 8; j++) begin
      apply(8'h00, sel_of(j));
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      n_chk++;
      if (bus.y !== 1'b0 || exp !== 1'b0) begin
        n_fail++;
        $display("FAIL all_zero[%0d]: y=%b want 0", j, bus.y);
      end
    end
  endtask

  task automatic test_latency_hold;
    logic [7:0] iv;
    iv = 8'h00;
    apply(iv, 3'b000);
    @(posedge clk);
    #1;
    void'(sb.pop_front());
    for (int c = 0; c < 4; c++) begin
      held = bus.y;
      iv[0] = ~iv[0];
      apply(iv, 3'b000);
      #1;
      n_chk++;
      if (bus.y !== held) begin
        n_fail++;
        $display("FAIL lat_hold[%0d]: y=%b want %b", c, bus.y, held);
      end
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      n_chk++;
      if (bus.y !== exp || exp !== iv[0]) begin
        n_fail++;
        $display("FAIL lat_edge[%0d]: y=%b want %b", c, bus.y, iv[0]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      held = bus.y;
      iv[7] = ~iv[7];
      apply(iv, 3'b000);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      n_chk++;
      if (bus.y !== held || exp !== held) begin
        n_fail++;
        $display("FAIL lane7_toggle[%0d]: y=%b want %b", c, bus.y, held);
      end
    end
  endtask

  task automatic test_reset_mid;
    apply(8'h10, 3'b001);
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    n_chk++;
    if (bus.y !== 1'b1 || exp !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: y=%b want 1", bus.y);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.y !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: y=%b want 0", bus.y);
    end
    #1;
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (bus.y !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after_rel: y=%b want 0", bus.y);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (bus.y !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_recover: y=%b want 1", bus.y);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] iv;
    logic [2:0] sv;
    for (int c = 0; c < 20; c++) begin
      iv = 8'($urandom_range(0, 255));
      sv = 3'($urandom_range(0, 7));
      apply(iv, sv);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      n_chk++;
      if (bus.y !== exp) begin
        n_fail++;
        $display("FAIL b2b[%0d] i=%h s=%b: y=%b want %b",
                 c, iv, sv, bus.y, exp);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_walking_one();
    test_walking_zero();
    test_all_zero();
    test_latency_hold();
    test_reset_mid();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_left: %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
